// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined signed adder tree with a registered shift, round and
// saturate output stage.
//
// The TERM_SIZE input terms are summed in a balanced binary tree with one register per level.
// At a level with an odd number of inputs, the last element is registered unchanged, so every
// path through the tree has the same depth. The final stage rounds (half-up) or truncates,
// shifts right arithmetically, then clamps or wraps to OUT_BIT bits. A valid bit travels
// alongside the data. Data registers load whether or not the sample is valid.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset; clears every register
//   ce         clock enable; 0 holds every pipeline and output register
//   in_valid   term_in carries a valid sample this cycle
//   term_in    packed signed terms; term k = term_in[TERM_WIDTH*k +: TERM_WIDTH]
//   sat_clr    clears sat_flag (a set in the same cycle wins)
//   q          signed, shifted, rounded, saturated/wrapped sum
//   out_valid  q carries a valid result
//   sat_flag   sticky: a valid result was outside the OUT_BIT signed range
//
// Latency is $clog2(TERM_SIZE)+1 enabled cycles.

module adder_tree_pipe #(
  parameter int unsigned TERM_WIDTH = 24,
  parameter int unsigned TERM_SIZE  = 49,
  parameter int unsigned OUT_BIT    = 9,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned ROUND      = 1,
  parameter int unsigned SAT        = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             in_valid,
  input  logic [TERM_WIDTH*TERM_SIZE-1:0]  term_in,
  input  logic                             sat_clr,
  output logic [OUT_BIT-1:0]               q,
  output logic                             out_valid,
  output logic                             sat_flag
);

  localparam int unsigned LEVELS = $clog2(TERM_SIZE);
  localparam int unsigned ACC_W  = TERM_WIDTH + LEVELS;

  // Number of nodes at tree level n (level 0 = the input terms).
  function automatic int unsigned lvl_cnt(int unsigned n);
    return (TERM_SIZE + (32'd1 << n) - 1) >> n;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Adder tree
  // ---------------------------------------------------------------------------------------------
  for (genvar n = 0; n <= LEVELS; n++) begin : g_lvl
    localparam int unsigned Cnt = lvl_cnt(n);

    logic signed [ACC_W-1:0] node_q [Cnt];

    if (n == 0) begin : g_in
      // Level 0 is combinational: the terms are sign-extended to the accumulator width.
      for (genvar k = 0; k < Cnt; k++) begin : g_term
        logic signed [TERM_WIDTH-1:0] term;
        assign term      = term_in[TERM_WIDTH*k +: TERM_WIDTH];
        assign node_q[k] = ACC_W'(term);
      end
    end else begin : g_add
      localparam int unsigned PrevCnt = lvl_cnt(n - 1);
      localparam int unsigned Pairs   = PrevCnt / 2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < Cnt; i++) begin
            node_q[i] <= '0;
          end
        end else if (ce) begin
          for (int i = 0; i < Pairs; i++) begin
            node_q[i] <= g_lvl[n-1].node_q[2*i] + g_lvl[n-1].node_q[2*i+1];
          end
          // Odd count: the unpaired last node is registered unchanged to keep alignment.
          if (PrevCnt % 2 == 1) begin
            node_q[Cnt-1] <= g_lvl[n-1].node_q[PrevCnt-1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Final stage: round, shift, saturate/wrap
  // ---------------------------------------------------------------------------------------------
  localparam logic signed [ACC_W:0] RndAdd =
      (ROUND != 0 && SHIFT > 0) ? ((ACC_W+1)'(1) << (SHIFT - 1)) : '0;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   shifted;
  logic                    ovf;
  logic [OUT_BIT-1:0]      q_d;

  assign sum = g_lvl[LEVELS].node_q[0];

  always_comb begin
    rnd_sum = (ACC_W+1)'(sum) + RndAdd;
    shifted = rnd_sum >>> SHIFT;
    // In range only when every bit from the output sign bit upward is a copy of the sign.
    ovf     = !((&shifted[ACC_W:OUT_BIT-1]) || !(|shifted[ACC_W:OUT_BIT-1]));
    q_d     = shifted[OUT_BIT-1:0];
    if (ovf && SAT != 0) begin
      q_d = shifted[ACC_W] ? {1'b1, {(OUT_BIT-1){1'b0}}} : {1'b0, {(OUT_BIT-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Valid tracking and output registers
  // ---------------------------------------------------------------------------------------------
  // vld_all[k] marks the sample entering stage k; vld_all[LEVELS] enters the final stage.
  logic [LEVELS:0]   vld_q;
  logic [LEVELS+1:0] vld_all;
  logic [OUT_BIT-1:0] q_q;
  logic               sat_q;

  assign vld_all = {vld_q, in_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      q_q   <= '0;
    end else if (ce) begin
      vld_q <= vld_all[LEVELS:0];
      q_q   <= q_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (ce && vld_all[LEVELS] && ovf) begin
      sat_q <= 1'b1;
    end else if (sat_clr) begin
      sat_q <= 1'b0;
    end
  end

  assign q         = q_q;
  assign out_valid = vld_all[LEVELS+1];
  assign sat_flag  = sat_q;

endmodule
